// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/result bundle between a converter requester and bin_to_bcd_seq.
//   start    : request a conversion of bin_in (requester -> converter)
//   bin_in   : unsigned binary value to convert (requester -> converter)
//   busy     : conversion in progress (converter -> requester)
//   done     : one-cycle pulse when big_bin has been updated
//   overflow : last accepted bin_in exceeded the displayable maximum
//   big_bin  : four packed 5-bit digit codes {blank, bcd[3:0]}, thousands in [19:15]
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W = 14
);
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [19:0]      big_bin;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  overflow,
        input  big_bin
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output overflow,
        output big_bin
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Feeds the multiplexed seven-segment display; the result is held stable between
// conversions so the display never shows a partially converted value.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bin_to_bcd_seq_if.slave (start, bin_in in; busy, done, overflow, big_bin out)
//
// Optional feature macro: BIN_TO_BCD_LZ_BLANK_EN
//   defined   : leading zero digits (thousands..tens) are output as 5'b10000 (blanked)
//   undefined : all four digits are shown, bit 4 of every field is 0
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned OUT_W = 5 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

    state_e             r_state;
    logic [BIN_W-1:0]   r_shreg;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;  // overflow of the value in flight, published in FINISH
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;
    logic [OUT_W-1:0]   r_big_bin;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [OUT_W-1:0]   w_big_bin;
    logic               w_in_ovf;

    assign w_in_ovf = (bus.bin_in > MAX_BIN);

    // Add-3 correction on every nibble >= 5 before the shift; nibbles are <= 9 so no carry.
    always_comb begin
        w_bcd_adj = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4];
            end
        end
    end

`ifdef BIN_TO_BCD_LZ_BLANK_EN
    logic w_lead;

    // Blank leading zeros from the most significant digit down; units always shown.
    always_comb begin
        w_big_bin = '0;
        w_lead    = 1'b1;
        for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
            if (w_lead && (r_bcd[4*d +: 4] == 4'd0)) begin
                w_big_bin[5*d +: 5] = 5'b10000;
            end else begin
                w_lead              = 1'b0;
                w_big_bin[5*d +: 5] = {1'b0, r_bcd[4*d +: 4]};
            end
        end
        w_big_bin[4:0] = {1'b0, r_bcd[3:0]};
    end
`else
    always_comb begin
        w_big_bin = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            w_big_bin[5*d +: 5] = {1'b0, r_bcd[4*d +: 4]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shreg    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_big_bin  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_shreg    <= w_in_ovf ? MAX_BIN : bus.bin_in;
                        r_bcd      <= '0;
                        r_cnt      <= CNT_W'(BIN_W);
                        r_ovf_pend <= w_in_ovf;
                        r_busy     <= 1'b1;
                        r_state    <= StShift;
                    end
                end
                StShift: begin
                    {r_bcd, r_shreg} <= {w_bcd_adj[BCD_W-2:0], r_shreg, 1'b0};
                    r_cnt            <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= StFinish;
                    end
                end
                StFinish: begin
                    r_big_bin  <= w_big_bin;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.big_bin  = r_big_bin;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: random and directed conversions checked
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [19:0] exp_big;
    logic        exp_ovf;

    bin_to_bcd_seq_if #(.BIN_W(14)) bus ();

    bin_to_bcd_seq #(
        .BIN_W  (14),
        .DIGITS (4),
        .MAX_VAL(9999)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: clamp, split into decimal digits, pack as {blank, digit} fields.
    function automatic logic [19:0] model_pack(input int v);
        int          val;
        int          dig[4];
        logic [19:0] r;
        bit          lead;
        val    = (v > 9999) ? 9999 : v;
        dig[0] = val % 10;
        dig[1] = (val / 10) % 10;
        dig[2] = (val / 100) % 10;
        dig[3] = val / 1000;
        r      = '0;
        lead   = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            r[k*5 +: 5] = {1'b0, 4'(dig[k])};
`ifdef BIN_TO_BCD_LZ_BLANK_EN
            if (lead && k > 0 && dig[k] == 0) r[k*5 +: 5] = 5'b10000;
            else lead = 1'b0;
`endif
        end
        return r;
    endfunction

    // Runs one conversion. pa/pb: sample indices at which a stray start is driven.
    // ra: index at which rst_n is pulled low for one edge (0 = none).
    task automatic run_conv(input int v, input int pa, input int pb, input int ra,
                            output int lat, output int ndone, output int busy_cnt,
                            output int hold_err);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'(v);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0; ndone = 0; busy_cnt = 0; hold_err = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = i;
            end
            if (ra == 0 && i >= 1 && i <= 14 &&
                (bus.big_bin !== exp_big || bus.overflow !== exp_ovf)) hold_err++;
            if (i == pa || i == pb) begin
                bus.start  = 1'b1;
                bus.bin_in = 14'd42;
            end else begin
                bus.start = 1'b0;
            end
            rst_n = (ra > 0 && i == ra) ? 1'b0 : 1'b1;
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
    endtask

    // Full conversion with result, timing and hold checks.
    task automatic conv_check(input string name, input int v);
        int lat, ndone, busy_cnt, hold_err;
        logic [19:0] want_big;
        logic        want_ovf;
        want_big = model_pack(v);
        want_ovf = (v > 9999);
        run_conv(v, -1, -1, 0, lat, ndone, busy_cnt, hold_err);
        checks++;
        if (bus.big_bin !== want_big) begin
            errors++;
            $display("FAIL %s big_bin v=%0d got %h want %h", name, v, bus.big_bin, want_big);
        end
        checks++;
        if (bus.overflow !== want_ovf) begin
            errors++;
            $display("FAIL %s overflow v=%0d got %b want %b", name, v, bus.overflow, want_ovf);
        end
        checks++;
        if (lat !== 15 || ndone !== 1 || busy_cnt !== 15) begin
            errors++;
            $display("FAIL %s timing v=%0d got lat=%0d dones=%0d busy=%0d want 15/1/15",
                     name, v, lat, ndone, busy_cnt);
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL %s hold v=%0d got %0d changes want 0", name, v, hold_err);
        end
        exp_big = want_big;
        exp_ovf = want_ovf;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b1;  // start during reset must lose
        bus.bin_in = 14'd123;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.big_bin !== 20'h00000) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b ovf=%b big=%h want 0/0/0/00000",
                     bus.busy, bus.done, bus.overflow, bus.big_bin);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        exp_big   = 20'h00000;
        exp_ovf   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_directed();
        conv_check("zero", 0);
        conv_check("v1234", 1234);
        conv_check("v9999", 9999);
        conv_check("v12000", 12000);
        conv_check("v7", 7);
        conv_check("v1005", 1005);
        conv_check("v0_again", 0);
        conv_check("vmax_in", 16383);
        conv_check("v10000", 10000);
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 24; n++) begin
            v = (n % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            conv_check("random", v);
        end
    endtask

    task automatic test_ignore_start();
        int lat, ndone, busy_cnt, hold_err;
        run_conv(1234, 3, 10, 0, lat, ndone, busy_cnt, hold_err);
        checks++;
        if (bus.big_bin !== model_pack(1234) || ndone !== 1 || lat !== 15) begin
            errors++;
            $display("FAIL ignore_start got big=%h dones=%0d lat=%0d want %h/1/15",
                     bus.big_bin, ndone, lat, model_pack(1234));
        end
        checks++;
        if (busy_cnt !== 15 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_busy got busy_cnt=%0d busy=%b want 15/0",
                     busy_cnt, bus.busy);
        end
        exp_big = model_pack(1234);
        exp_ovf = 1'b0;
    endtask

    task automatic test_mid_reset();
        int lat, ndone, busy_cnt, hold_err;
        conv_check("pre_reset", 1234);
        run_conv(5678, -1, -1, 7, lat, ndone, busy_cnt, hold_err);
        checks++;
        if (ndone !== 0 || bus.busy !== 1'b0 || bus.big_bin !== 20'h00000 ||
            bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got dones=%0d busy=%b big=%h ovf=%b want 0/0/00000/0",
                     ndone, bus.busy, bus.big_bin, bus.overflow);
        end
        exp_big = 20'h00000;
        exp_ovf = 1'b0;
        conv_check("post_reset", 42);
    endtask

    task automatic test_back_to_back();
        int first, second, ndone, a, b;
        a = int'($urandom_range(0, 9999));
        b = int'($urandom_range(0, 9999));
        first = -1; second = -1; ndone = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'(a);
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) bus.bin_in = 14'(b);
            if (j == 16) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first < 0) first = j;
                else if (second < 0) second = j;
            end
            if (j == 15) begin
                checks++;
                if (bus.big_bin !== model_pack(a)) begin
                    errors++;
                    $display("FAIL b2b_first got %h want %h", bus.big_bin, model_pack(a));
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (first !== 15 || second !== 31 || ndone !== 2) begin
            errors++;
            $display("FAIL b2b_timing got first=%0d second=%0d dones=%0d want 15/31/2",
                     first, second, ndone);
        end
        checks++;
        if (bus.big_bin !== model_pack(b)) begin
            errors++;
            $display("FAIL b2b_second got %h want %h", bus.big_bin, model_pack(b));
        end
        exp_big = model_pack(b);
        exp_ovf = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        exp_big    = '0;
        exp_ovf    = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
